// File: rtl/note_sequencer_ctrl.sv
// note_sequencer_ctrl: steps a programmable {note, duration} table through the
// note player. Durations are counted in external tick pulses.
// Optional: define NOTE_SEQ_GAP_EN to insert a one-tick silence (GAP) after
// every note; without it notes play back to back.
module note_sequencer_ctrl #(
  parameter  int SEQ_LEN = 8,
  parameter  int NOTE_W  = 3,
  parameter  int DUR_W   = 8,
  localparam int PW      = $clog2(SEQ_LEN),
  localparam int LW      = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [LW-1:0]     seq_len,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic [NOTE_W-1:0] note_sel,
  output logic              player_en,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_LOAD = 4'b1000,
    S_PLAY = 4'b0100,
    S_GAP  = 4'b0010,
    S_DONE = 4'b0001
  } state_t;

  state_t            cur_state, nxt_state, adv_state;
  logic [NOTE_W-1:0] note_tab [SEQ_LEN];
  logic [DUR_W-1:0]  dur_tab  [SEQ_LEN];
  logic [PW-1:0]     ptr, ptr_nxt, adv_ptr;
  logic [LW-1:0]     len_r, len_nxt;
  logic              loop_r, loop_nxt;
  logic [DUR_W-1:0]  dur_cnt, cnt_nxt;
  logic [NOTE_W-1:0] note_nxt;
  logic              last;

  assign state     = cur_state;
  assign player_en = (cur_state == S_PLAY);
  assign busy      = (cur_state != S_IDLE);
  assign done      = (cur_state == S_DONE);

  // Table is only writable while idle so a running melody never changes under us.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        note_tab[i] <= '0;
        dur_tab[i]  <= '0;
      end
    end else if (wr_en && cur_state == S_IDLE) begin
      note_tab[wr_addr] <= wr_note;
      dur_tab[wr_addr]  <= wr_dur;
    end
  end

  // Advance rule: wrap when looping, finish on the last entry, else next entry.
  assign last = ({1'b0, ptr} == (len_r - LW'(1)));

  always_comb begin
    adv_state = S_LOAD;
    adv_ptr   = ptr + PW'(1);
    if (last) begin
      if (loop_r) begin
        adv_ptr = '0;
      end else begin
        adv_state = S_DONE;
        adv_ptr   = ptr;
      end
    end
  end

  // Next-state and datapath next values; stop overrides everything when busy.
  always_comb begin
    nxt_state = cur_state;
    ptr_nxt   = ptr;
    len_nxt   = len_r;
    loop_nxt  = loop_r;
    cnt_nxt   = dur_cnt;
    note_nxt  = note_sel;
    case (cur_state)
      S_IDLE: begin
        if (start && seq_len != '0) begin
          nxt_state = S_LOAD;
          ptr_nxt   = '0;
          len_nxt   = (seq_len > LW'(SEQ_LEN)) ? LW'(SEQ_LEN) : seq_len;
          loop_nxt  = loop;
        end
      end
      S_LOAD: begin
        if (dur_tab[ptr] != '0) begin
          note_nxt  = note_tab[ptr];
          cnt_nxt   = dur_tab[ptr];
          nxt_state = S_PLAY;
        end else begin
          // zero-duration entries are skipped without touching note_sel
          nxt_state = adv_state;
          ptr_nxt   = adv_ptr;
        end
      end
      S_PLAY: begin
        if (tick) begin
          cnt_nxt = dur_cnt - DUR_W'(1);
          if (dur_cnt == DUR_W'(1)) begin
`ifdef NOTE_SEQ_GAP_EN
            nxt_state = S_GAP;
`else
            nxt_state = adv_state;
            ptr_nxt   = adv_ptr;
`endif
          end
        end
      end
      S_GAP: begin
`ifdef NOTE_SEQ_GAP_EN
        if (tick) begin
          nxt_state = adv_state;
          ptr_nxt   = adv_ptr;
        end
`else
        nxt_state = S_IDLE;
`endif
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    if (stop && cur_state != S_IDLE) nxt_state = S_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      ptr       <= '0;
      len_r     <= '0;
      loop_r    <= 1'b0;
      dur_cnt   <= '0;
      note_sel  <= '0;
    end else begin
      cur_state <= nxt_state;
      ptr       <= ptr_nxt;
      len_r     <= len_nxt;
      loop_r    <= loop_nxt;
      dur_cnt   <= cnt_nxt;
      note_sel  <= note_nxt;
    end
  end

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Directed bench for note_sequencer_ctrl; expectations follow the GAP build
// option so the same bench covers both configurations.
module tb_note_sequencer_ctrl;

  localparam int SEQ_LEN = 8;
  localparam int NOTE_W  = 3;
  localparam int DUR_W   = 8;
  localparam int PW      = $clog2(SEQ_LEN);
  localparam int LW      = PW + 1;

  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] LOAD = 4'b1000;
  localparam logic [3:0] PLAY = 4'b0100;
  localparam logic [3:0] GAP  = 4'b0010;
  localparam logic [3:0] DONE = 4'b0001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [LW-1:0]     seq_len = '0;
  logic              wr_en = 1'b0;
  logic [PW-1:0]     wr_addr = '0;
  logic [NOTE_W-1:0] wr_note = '0;
  logic [DUR_W-1:0]  wr_dur = '0;
  logic [NOTE_W-1:0] note_sel;
  logic              player_en, busy, done;
  logic [3:0]        state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int saw4_cnt = 0;
  int d0, s0;

  note_sequencer_ctrl #(.SEQ_LEN(SEQ_LEN), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .loop(loop),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
    .wr_dur(wr_dur), .note_sel(note_sel), .player_en(player_en), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Count done pulses and any playback of note 4, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (player_en && note_sel == 3'd4) saw4_cnt <= saw4_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given tick level; outputs sampled 1ns after the edge.
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // One tick period: three quiet cycles then a tick cycle.
  task automatic tk();
    repeat (3) step(1'b0);
    step(1'b1);
  endtask

  // Final tick of a note, plus the silent gap when that build option is on.
  task automatic finish_entry(input string tag, input logic [3:0] exp_state);
    tk();
`ifdef NOTE_SEQ_GAP_EN
    chk({tag, "_gap"}, 32'(state), 32'(GAP));
    chk({tag, "_gap_en"}, 32'(player_en), 32'd0);
    tk();
`endif
    chk(tag, 32'(state), 32'(exp_state));
  endtask

  task automatic wr(input int a, input int n, input int d);
    wr_en = 1'b1; wr_addr = PW'(a); wr_note = NOTE_W'(n); wr_dur = DUR_W'(d);
    step(1'b0);
    wr_en = 1'b0;
  endtask

  task automatic play_chk(input string tag, input int n);
    step(1'b0);
    chk({tag, "_state"}, 32'(state), 32'(PLAY));
    chk({tag, "_note"}, 32'(note_sel), 32'(n));
    chk({tag, "_en"}, 32'(player_en), 32'd1);
  endtask

  task automatic go(input int len, input logic lp);
    seq_len = LW'(len); loop = lp; start = 1'b1;
    step(1'b0);
    start = 1'b0;
  endtask

  initial begin
    // reset held from time zero
    #12;
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(player_en), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // reach PLAY, then apply reset mid-cycle
    wr(0, 1, 2); wr(1, 5, 1); wr(2, 3, 3);
    go(3, 1'b0);
    play_chk("pre_rst", 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'(IDLE));
    chk("arst_note", 32'(note_sel), 32'd0);
    chk("arst_en", 32'(player_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // basic sequence, no loop
    wr(0, 1, 2); wr(1, 5, 1); wr(2, 3, 3);
    d0 = done_cnt;
    go(3, 1'b0);
    chk("b_load", 32'(state), 32'(LOAD));
    chk("b_load_busy", 32'(busy), 32'd1);
    play_chk("b_e0", 1);
    tk();
    chk("b_e0_t1", 32'(state), 32'(PLAY));
    finish_entry("b_e0_end", LOAD);
    play_chk("b_e1", 5);
    finish_entry("b_e1_end", LOAD);
    play_chk("b_e2", 3);
    tk(); tk();
    chk("b_e2_t2", 32'(note_sel), 32'd3);
    finish_entry("b_e2_end", DONE);
    chk("b_done", 32'(done), 32'd1);
    chk("b_done_note", 32'(note_sel), 32'd3);
    step(1'b0);
    chk("b_idle", 32'(state), 32'(IDLE));
    chk("b_done_once", 32'(done_cnt - d0), 32'd1);

    // loop, ignored write/start while busy, then stop
    d0 = done_cnt;
    go(3, 1'b1);
    play_chk("l_e0", 1);
    tk();
    finish_entry("l_e0_end", LOAD);
    play_chk("l_e1", 5);
    finish_entry("l_e1_end", LOAD);
    play_chk("l_e2", 3);
    tk(); tk();
    finish_entry("l_wrap", LOAD);
    play_chk("l_again", 1);
    wr(0, 7, 9);
    start = 1'b1; seq_len = 4'd1; loop = 1'b0;
    step(1'b0);
    start = 1'b0;
    chk("l_start_busy", 32'(state), 32'(PLAY));
    stop = 1'b1;
    step(1'b0);
    stop = 1'b0;
    chk("l_stop_state", 32'(state), 32'(IDLE));
    chk("l_stop_en", 32'(player_en), 32'd0);
    step(1'b0);
    chk("l_no_done", 32'(done_cnt - d0), 32'd0);

    // table unchanged by the write made during PLAY
    go(1, 1'b0);
    play_chk("t_e0", 1);
    tk();
    chk("t_dur2", 32'(state), 32'(PLAY));
    finish_entry("t_end", DONE);
    step(1'b0);

    // zero-duration skip
    wr(0, 2, 2); wr(1, 4, 0); wr(2, 6, 1);
    s0 = saw4_cnt;
    go(3, 1'b0);
    play_chk("z_e0", 2);
    tk();
    finish_entry("z_e0_end", LOAD);
    step(1'b0);
    chk("z_skip_state", 32'(state), 32'(LOAD));
    chk("z_skip_note", 32'(note_sel), 32'd2);
    play_chk("z_e2", 6);
    finish_entry("z_end", DONE);
    step(1'b0);
    chk("z_no4", 32'(saw4_cnt - s0), 32'd0);

    // seq_len zero start is ignored
    d0 = done_cnt;
    go(0, 1'b0);
    chk("sl0_state", 32'(state), 32'(IDLE));
    step(1'b0); step(1'b0);
    chk("sl0_done", 32'(done_cnt - d0), 32'd0);

    // clamp: seq_len 12 plays all 8 entries
    for (int i = 0; i < SEQ_LEN; i++) wr(i, i, 1);
    go(12, 1'b0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      play_chk($sformatf("c_e%0d", i), i);
      finish_entry($sformatf("c_e%0d_end", i), (i == SEQ_LEN - 1) ? DONE : LOAD);
    end
    step(1'b0);
    chk("c_idle", 32'(state), 32'(IDLE));

    // stop together with the final tick of the last note
    wr(0, 3, 1);
    d0 = done_cnt;
    go(1, 1'b0);
    play_chk("st_e0", 3);
    stop = 1'b1;
    step(1'b1);
    stop = 1'b0;
    chk("st_state", 32'(state), 32'(IDLE));
    step(1'b0); step(1'b0);
    chk("st_no_done", 32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
